seg7_display_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 70 +++++++
 rtl/seg7_display_driver_bcd.sv | 97 +++++++++
 rtl/seg7_display_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_display_driver.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and helpers for the 7-segment display driver:
//                double-dabble FSM state encoding, 4-bit digit code type,
//                BCD add-3 adjust step and the digit-to-segment decoder.
//  Contents    : dd_state_e    - IDLE / SHIFT / COMMIT
//                digit_e       - 0..9, DIG_MINUS (4'hA), DIG_BLANK (4'hF)
//                bcd_adjust()  - add 3 to every BCD nibble >= 5
//                digit_to_seg()- active-high {g,f,e,d,c,b,a} pattern
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } dd_state_e;

   typedef enum logic [3:0] {
      DIG_0     = 4'h0,
      DIG_1     = 4'h1,
      DIG_2     = 4'h2,
      DIG_3     = 4'h3,
      DIG_4     = 4'h4,
      DIG_5     = 4'h5,
      DIG_6     = 4'h6,
      DIG_7     = 4'h7,
      DIG_8     = 4'h8,
      DIG_9     = 4'h9,
      DIG_MINUS = 4'hA,
      DIG_BLANK = 4'hF
   } digit_e;

   // Pre-shift correction of the double-dabble: any nibble that would
   // reach 10 or more after doubling is pushed over into the next decade.
   function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
      logic [11:0] r;
      r = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Segment pattern {g,f,e,d,c,b,a}, 1 = segment lit.
   function automatic logic [6:0] digit_to_seg(input digit_e code);
      logic [6:0] s;
      case (code)
         DIG_0:     s = 7'b0111111;
         DIG_1:     s = 7'b0000110;
         DIG_2:     s = 7'b1011011;
         DIG_3:     s = 7'b1001111;
         DIG_4:     s = 7'b1100110;
         DIG_5:     s = 7'b1101101;
         DIG_6:     s = 7'b1111101;
         DIG_7:     s = 7'b0000111;
         DIG_8:     s = 7'b1111111;
         DIG_9:     s = 7'b1101111;
         DIG_MINUS: s = 7'b1000000;
         default:   s = 7'b0000000;
      endcase
      return s;
   endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_display_driver_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_double_dabble
//  Description : Sequential 8-bit binary to 3-digit BCD converter with
//                optional two's-complement interpretation. One shift per
//                clock: start edge, 8 shift edges, 1 commit edge.
//  Ports       : clk          - system clock
//                resetn       - asynchronous active-low reset
//                start_i      - begin a conversion (honoured in IDLE only)
//                value_i      - 8-bit operand
//                non_signed_i - 1 = unsigned, 0 = two's complement
//                busy_o       - FSM not in IDLE
//                done_o       - one-cycle strobe in COMMIT; outputs valid
//                sign_o       - operand was negative
//                hundreds_o / tens_o / ones_o - BCD digits of |value|
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_double_dabble
   import seg7_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       start_i,
   input  logic [7:0] value_i,
   input  logic       non_signed_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       sign_o,
   output logic [3:0] hundreds_o,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   dd_state_e   state_q, state_d;
   logic [11:0] bcd_q,   bcd_d;
   logic [7:0]  mag_q,   mag_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic        sign_q,  sign_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         bcd_q   <= '0;
         mag_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sign_d  = ~non_signed_i & value_i[7];
               // -128 negates to 8'h80, which is correctly read as 128.
               mag_d   = sign_d ? (~value_i + 8'd1) : value_i;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {bcd_d, mag_d} = {bcd_adjust(bcd_q), mag_q} << 1;
            cnt_d          = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_COMMIT);
   assign sign_o     = sign_q;
   assign hundreds_o = bcd_q[11:8];
   assign tens_o     = bcd_q[7:4];
   assign ones_o     = bcd_q[3:0];

endmodule : bcd_double_dabble
`default_nettype wire

// File: rtl/seg7_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_display_driver
//  Description : Shows an 8-bit CPU result as sign + 3 decimal digits on a
//                4-digit multiplexed common-segment 7-segment display, with
//                leading-zero blanking and signed/unsigned selection.
//  Ports       : clk        - system clock
//                resetn     - asynchronous active-low reset
//                value      - number to display
//                non_signed - 1 = unsigned, 0 = two's complement
//                blank      - 1 = all digits off (conversion keeps running)
//                seg        - {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//                an         - one-hot digit enable, an[3] sign, an[0] ones
//                busy       - conversion in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] value,
   input  logic       non_signed,
   input  logic       blank,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       busy
);

   localparam int             CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0]     AN_OFF   = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;

   // ---------------------------------------------------------------- convert
   logic       dd_busy, dd_done, dd_sign, dd_start;
   logic [3:0] dd_hund, dd_tens, dd_ones;

   logic [8:0] shadow_q;
   logic       shadow_valid_q;

   // A new conversion is requested whenever the displayed operand is stale;
   // changes arriving mid-conversion are caught here once the FSM is idle.
   assign dd_start = ~dd_busy &
                     (~shadow_valid_q | ({non_signed, value} != shadow_q));

   bcd_double_dabble u_bcd (
      .clk          (clk),
      .resetn       (resetn),
      .start_i      (dd_start),
      .value_i      (value),
      .non_signed_i (non_signed),
      .busy_o       (dd_busy),
      .done_o       (dd_done),
      .sign_o       (dd_sign),
      .hundreds_o   (dd_hund),
      .tens_o       (dd_tens),
      .ones_o       (dd_ones)
   );

   assign busy = dd_busy;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow_q       <= '0;
         shadow_valid_q <= 1'b0;
      end else begin
         if (dd_start) begin
            shadow_q <= {non_signed, value};
         end
         if (dd_done) begin
            shadow_valid_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- digits
   digit_e sign_dig_q, hund_dig_q, tens_dig_q, ones_dig_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sign_dig_q <= DIG_BLANK;
         hund_dig_q <= DIG_BLANK;
         tens_dig_q <= DIG_BLANK;
         ones_dig_q <= DIG_BLANK;
      end else if (dd_done) begin
         sign_dig_q <= dd_sign ? DIG_MINUS : DIG_BLANK;
         hund_dig_q <= (dd_hund == 4'd0) ? DIG_BLANK : digit_e'(dd_hund);
         tens_dig_q <= ((dd_hund == 4'd0) && (dd_tens == 4'd0)) ?
                       DIG_BLANK : digit_e'(dd_tens);
         ones_dig_q <= digit_e'(dd_ones);
      end
   end

   // ---------------------------------------------------------------- scan
   logic [CNT_W-1:0] refresh_cnt_q;
   logic [1:0]       scan_idx_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         refresh_cnt_q <= '0;
         scan_idx_q    <= 2'd0;
      end else if (refresh_cnt_q == CNT_LAST) begin
         refresh_cnt_q <= '0;
         scan_idx_q    <= scan_idx_q + 2'd1;
      end else begin
         refresh_cnt_q <= refresh_cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------- output
   digit_e     sel_dig;
   logic [6:0] seg_d;
   logic [3:0] an_d;
   logic [6:0] seg_q;
   logic [3:0] an_q;

   always_comb begin
      sel_dig = DIG_BLANK;
      case (scan_idx_q)
         2'd0:    sel_dig = ones_dig_q;
         2'd1:    sel_dig = tens_dig_q;
         2'd2:    sel_dig = hund_dig_q;
         default: sel_dig = sign_dig_q;
      endcase
   end

   always_comb begin
      seg_d = 7'b0;
      an_d  = 4'b0;
      if (!blank) begin
         seg_d = digit_to_seg(sel_dig);
         an_d  = 4'b0001 << scan_idx_q;
      end
   end

   // seg and an change together on one edge, so no digit ever shows its
   // neighbour's pattern.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         seg_q <= SEG_OFF;
         an_q  <= AN_OFF;
      end else begin
         seg_q <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
         an_q  <= SEG_ACTIVE_LOW ? ~an_d  : an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule : seg7_display_driver
`default_nettype wire

// File: tb/tb_seg7_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_display_driver
//  Description : Self-checking bench for seg7_display_driver with
//                REFRESH_DIV = 4 and active-high outputs. Expected digits
//                come from a decimal-arithmetic model of the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display_driver;

   logic       clk        = 1'b0;
   logic       resetn     = 1'b0;
   logic [7:0] value      = 8'd0;
   logic       non_signed = 1'b1;
   logic       blank      = 1'b0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [6:0] exp_seg  [4];
   logic [6:0] obs_seg  [4];
   bit         obs_seen [4];
   logic [7:0] last_v   = 8'd0;
   logic       last_ns  = 1'b1;

   logic [7:0] dir_v  [5] = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h05};
   logic       dir_ns [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   seg7_display_driver #(
      .REFRESH_DIV    (4),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .value      (value),
      .non_signed (non_signed),
      .blank      (blank),
      .seg        (seg),
      .an         (an),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (time %0t, required < 500000)", $time);
      $fatal(1);
   end

   // ------------------------------------------------------------ model
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic set_expected(input logic [7:0] v, input logic ns);
      int s, m, h, t, o;
      s = ns ? int'(v) : int'($signed(v));
      m = (s < 0) ? -s : s;
      h = m / 100;
      t = (m / 10) % 10;
      o = m % 10;
      exp_seg[3] = (s < 0) ? 7'b1000000 : 7'b0000000;
      exp_seg[2] = (h != 0) ? seg_of(h) : 7'b0000000;
      exp_seg[1] = (h != 0 || t != 0) ? seg_of(t) : 7'b0000000;
      exp_seg[0] = seg_of(o);
   endtask

   function automatic int slot_of(input logic [3:0] a);
      case (a)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   // ------------------------------------------------------------ helpers
   task automatic observe(input int n);
      int k;
      for (int i = 0; i < 4; i++) begin
         obs_seen[i] = 1'b0;
         obs_seg[i]  = 7'b0;
      end
      repeat (n) begin
         @(negedge clk);
         k = slot_of(an);
         if (k >= 0) begin
            obs_seg[k]  = seg;
            obs_seen[k] = 1'b1;
         end
      end
   endtask

   task automatic wait_idle(output int cyc, output bit timed_out);
      cyc = 0;
      while (busy !== 1'b0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      timed_out = (busy !== 1'b0);
   endtask

   // Drives a new operand, waits for the conversion and samples a full scan.
   task automatic run_conv(input logic [7:0] v, input logic ns,
                           output bit busy_rose, output int busy_cyc,
                           output bit timed_out);
      @(negedge clk);
      value      = v;
      non_signed = ns;
      last_v     = v;
      last_ns    = ns;
      @(negedge clk);
      busy_rose = (busy === 1'b1);
      wait_idle(busy_cyc, timed_out);
      @(negedge clk);
      observe(17);
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      int  cyc;
      bit  to;
      resetn     = 1'b0;
      value      = 8'd0;
      non_signed = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || seg !== 7'b0 || an !== 4'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b seg=%b an=%b, required busy=0 seg=0000000 an=0000", busy, seg, an);
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_conv: busy=%b, required 1", busy);
      end
      wait_idle(cyc, to);
      checks++;
      if (to || cyc != 9) begin
         errors++;
         $display("FAIL reset_busy_len: busy high %0d cycles (timeout=%0d), required 9", cyc, to);
      end
      @(negedge clk);
      observe(17);
      set_expected(8'd0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (!obs_seen[k] || obs_seg[k] !== exp_seg[k]) begin
            errors++;
            $display("FAIL reset_digit%0d: seen=%0d seg=%b, required %b", k, obs_seen[k], obs_seg[k], exp_seg[k]);
         end
      end
      checks++;
      if (obs_seg[0] !== 7'b0111111) begin
         errors++;
         $display("FAIL reset_ones_zero: seg=%b, required 0111111", obs_seg[0]);
      end
   endtask

   task automatic test_values();
      bit rose, to;
      int cyc;
      for (int i = 0; i < 5; i++) begin
         run_conv(dir_v[i], dir_ns[i], rose, cyc, to);
         checks++;
         if (!rose || to || cyc != 9) begin
            errors++;
            $display("FAIL values%0d_busy: rose=%0d cycles=%0d timeout=%0d, required rose=1 cycles=9", i, rose, cyc, to);
         end
         set_expected(dir_v[i], dir_ns[i]);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (!obs_seen[k] || obs_seg[k] !== exp_seg[k]) begin
               errors++;
               $display("FAIL values%0d_digit%0d (v=%h ns=%b): seg=%b seen=%0d, required %b", i, k, dir_v[i], dir_ns[i], obs_seg[k], obs_seen[k], exp_seg[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc, nseen;
      bit to;
      @(negedge clk);
      value = 8'd10; non_signed = 1'b1;
      @(negedge clk);                       // after E0
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_start: busy=%b, required 1", busy);
      end
      @(negedge clk);                       // after E1
      @(negedge clk);                       // after E2
      value = 8'd99;                        // sampled at E3
      last_v = 8'd99; last_ns = 1'b1;
      wait_idle(cyc, to);                   // returns after E9
      checks++;
      if (to || cyc != 7) begin
         errors++;
         $display("FAIL b2b_first_done: cycles=%0d timeout=%0d, required 7", cyc, to);
      end
      @(negedge clk);                       // after E10
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rebusy: busy=%b, required 1", busy);
      end
      observe(9);                           // 10 still on display here
      set_expected(8'd10, 1'b1);
      nseen = 0;
      for (int k = 0; k < 4; k++) begin
         if (obs_seen[k]) begin
            nseen++;
            checks++;
            if (obs_seg[k] !== exp_seg[k]) begin
               errors++;
               $display("FAIL b2b_first_digit%0d: seg=%b, required %b", k, obs_seg[k], exp_seg[k]);
            end
         end
      end
      checks++;
      if (nseen < 2) begin
         errors++;
         $display("FAIL b2b_first_slots: %0d slots seen, required >= 2", nseen);
      end
      wait_idle(cyc, to);
      checks++;
      if (to || cyc > 2) begin
         errors++;
         $display("FAIL b2b_second_done: extra cycles=%0d timeout=%0d, required <= 2", cyc, to);
      end
      @(negedge clk);
      observe(17);
      set_expected(8'd99, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (!obs_seen[k] || obs_seg[k] !== exp_seg[k]) begin
            errors++;
            $display("FAIL b2b_final_digit%0d: seg=%b seen=%0d, required %b", k, obs_seg[k], obs_seen[k], exp_seg[k]);
         end
      end
   endtask

   task automatic test_scan_blank();
      logic [3:0] rec [24];
      int first, s0, n, slot;
      logic [3:0] exp_an;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         rec[i] = an;
      end
      first = 1;
      while (first < 5 && rec[first] === rec[first-1]) first++;
      s0 = slot_of(rec[first]);
      checks++;
      if (s0 < 0 || slot_of(rec[first-1]) < 0 ||
          s0 != (slot_of(rec[first-1]) + 1) % 4) begin
         errors++;
         $display("FAIL scan_step: an %b -> %b, required rotate-left one-hot", rec[first-1], rec[first]);
         s0 = 0;
      end
      for (int r = 0; r < 4; r++) begin
         exp_an = 4'b0001 << ((s0 + r) % 4);
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (rec[first + 4*r + j] !== exp_an) begin
               errors++;
               $display("FAIL scan_run%0d_%0d: an=%b, required %b", r, j, rec[first + 4*r + j], exp_an);
            end
         end
      end
      // rec[23] was sampled at cycle n = 23 relative to the recording.
      n = 23;
      blank = 1'b1;
      @(negedge clk); n++;
      checks++;
      if (seg !== 7'b0 || an !== 4'b0) begin
         errors++;
         $display("FAIL blank_on: seg=%b an=%b, required 0000000 0000", seg, an);
      end
      repeat (5) begin
         @(negedge clk); n++;
      end
      blank = 1'b0;
      @(negedge clk); n++;
      slot   = (s0 + (n - first) / 4) % 4;
      exp_an = 4'b0001 << slot;
      set_expected(last_v, last_ns);
      checks++;
      if (an !== exp_an || seg !== exp_seg[slot]) begin
         errors++;
         $display("FAIL blank_resume: an=%b seg=%b, required an=%b seg=%b", an, seg, exp_an, exp_seg[slot]);
      end
   endtask

   task automatic test_random();
      bit rose, to;
      int cyc;
      logic [7:0] v;
      logic ns;
      for (int i = 0; i < 8; i++) begin
         do begin
            v  = 8'($urandom_range(0, 255));
            ns = 1'($urandom_range(0, 1));
         end while (v == last_v && ns == last_ns);
         run_conv(v, ns, rose, cyc, to);
         checks++;
         if (!rose || to || cyc != 9) begin
            errors++;
            $display("FAIL rand%0d_busy: rose=%0d cycles=%0d timeout=%0d, required rose=1 cycles=9", i, rose, cyc, to);
         end
         set_expected(v, ns);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (!obs_seen[k] || obs_seg[k] !== exp_seg[k]) begin
               errors++;
               $display("FAIL rand%0d_digit%0d (v=%h ns=%b): seg=%b seen=%0d, required %b", i, k, v, ns, obs_seg[k], obs_seen[k], exp_seg[k]);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      int cyc;
      bit to;
      logic [7:0] v;
      v = (last_v == 8'd200 && last_ns) ? 8'd201 : 8'd200;
      @(negedge clk);
      value = v; non_signed = 1'b1;
      last_v = v; last_ns = 1'b1;
      repeat (3) @(negedge clk);            // now in SHIFT
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || seg !== 7'b0 || an !== 4'b0) begin
         errors++;
         $display("FAIL midreset_async: busy=%b seg=%b an=%b, required 0 0000000 0000", busy, seg, an);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset_restart: busy=%b, required 1", busy);
      end
      wait_idle(cyc, to);
      checks++;
      if (to || cyc != 9) begin
         errors++;
         $display("FAIL midreset_busy_len: cycles=%0d timeout=%0d, required 9", cyc, to);
      end
      @(negedge clk);
      observe(17);
      set_expected(v, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (!obs_seen[k] || obs_seg[k] !== exp_seg[k]) begin
            errors++;
            $display("FAIL midreset_digit%0d: seg=%b seen=%0d, required %b", k, obs_seg[k], obs_seen[k], exp_seg[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_values();
      test_back_to_back();
      test_scan_blank();
      test_random();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seg7_display_driver
`default_nettype wire
